// File: rtl/pipe_stall_ctrl.sv
// Central stall/bubble sequencer for the 5-stage pipeline (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
// Define PIPE_PERF_EN to build the three stall performance counters; otherwise they read 0.
module pipe_stall_ctrl #(
  parameter int TIMEOUT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_stall,
  input  logic        imem_done,
  input  logic        dmem_stall,
  input  logic        dmem_done,
  input  logic        load_use,
  input  logic        branch_flush,
  input  logic        halt_mem,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_bubble,
  output logic        idex_bubble,
  output logic        memwb_bubble,
  output logic        imem_cancel,
  output logic        halted,
  output logic        timeout_err,
  output logic [1:0]  state,
  output logic [15:0] stall_dmem_cnt,
  output logic [15:0] stall_imem_cnt,
  output logic [15:0] lu_bubble_cnt
);

  // RUN: flowing | IWAIT: fetch outstanding | DWAIT: data access outstanding | HALTED: stopped until reset
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    IWAIT  = 2'd1,
    DWAIT  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t state_q, state_nxt;
  logic   imem_pend, pend_nxt;
  logic   timeout_q;
  logic   in_wait;
  logic [TIMEOUT_W-1:0] wait_cnt, wait_inc;

  logic pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c;
  logic ifid_bub_c, idex_bub_c, memwb_bub_c, cancel_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      imem_pend <= 1'b0;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      imem_pend <= pend_nxt;
      if (state_nxt == RUN)
        wait_cnt <= '0;
      else if (in_wait)
        wait_cnt <= wait_inc;
      if (in_wait && (&wait_inc))
        timeout_q <= 1'b1;
    end
  end

  assign in_wait  = (state_q == IWAIT) || (state_q == DWAIT);
  assign wait_inc = (&wait_cnt) ? wait_cnt : wait_cnt + 1'b1;

  always_comb begin
    state_nxt   = state_q;
    pend_nxt    = imem_pend;
    pc_en_c     = 1'b1;
    ifid_en_c   = 1'b1;
    idex_en_c   = 1'b1;
    exmem_en_c  = 1'b1;
    memwb_en_c  = 1'b1;
    ifid_bub_c  = 1'b0;
    idex_bub_c  = 1'b0;
    memwb_bub_c = 1'b0;
    cancel_c    = 1'b0;
    case (state_q)
      RUN: begin
        if (dmem_stall) begin
          {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c} = 4'b0000;
          memwb_bub_c = 1'b1;
          pend_nxt    = imem_stall;
          state_nxt   = DWAIT;
        end else if (halt_mem) begin
          {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c} = 4'b0000;
          state_nxt = HALTED;
        end else if (branch_flush) begin
          ifid_bub_c = 1'b1;
          idex_bub_c = 1'b1;
          cancel_c   = imem_stall;
        end else if (imem_stall) begin
          pc_en_c = 1'b0;
          // a load-use hazard holds IF/ID instead, so the bubble moves down to ID/EX
          if (load_use) begin
            ifid_en_c  = 1'b0;
            idex_bub_c = 1'b1;
          end else begin
            ifid_bub_c = 1'b1;
          end
          state_nxt = IWAIT;
        end else if (load_use) begin
          pc_en_c    = 1'b0;
          ifid_en_c  = 1'b0;
          idex_bub_c = 1'b1;
        end
      end
      IWAIT: begin
        if (dmem_stall) begin
          {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c} = 4'b0000;
          memwb_bub_c = 1'b1;
          pend_nxt    = ~imem_done;
          state_nxt   = DWAIT;
        end else if (halt_mem) begin
          {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c} = 4'b0000;
          state_nxt = HALTED;
        end else if (branch_flush) begin
          ifid_bub_c = 1'b1;
          idex_bub_c = 1'b1;
          cancel_c   = 1'b1;
          state_nxt  = RUN;
        end else if (imem_done) begin
          if (load_use) begin
            pc_en_c    = 1'b0;
            ifid_en_c  = 1'b0;
            idex_bub_c = 1'b1;
          end
          state_nxt = RUN;
        end else begin
          pc_en_c = 1'b0;
          if (load_use) begin
            ifid_en_c  = 1'b0;
            idex_bub_c = 1'b1;
          end else begin
            ifid_bub_c = 1'b1;
          end
        end
      end
      DWAIT: begin
        pend_nxt = imem_pend & ~imem_done;
        if (dmem_done) begin
          state_nxt = pend_nxt ? IWAIT : RUN;
        end else begin
          {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c} = 4'b0000;
          memwb_bub_c = 1'b1;
        end
      end
      HALTED: begin
        {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c} = 5'b00000;
      end
      default: state_nxt = RUN;
    endcase
  end

  assign pc_en        = pc_en_c & ~rst;
  assign ifid_en      = ifid_en_c & ~rst;
  assign idex_en      = idex_en_c & ~rst;
  assign exmem_en     = exmem_en_c & ~rst;
  assign memwb_en     = memwb_en_c & ~rst;
  assign ifid_bubble  = ifid_bub_c & ~rst;
  assign idex_bubble  = idex_bub_c & ~rst;
  assign memwb_bubble = memwb_bub_c & ~rst;
  assign imem_cancel  = cancel_c & ~rst;
  assign halted       = (state_q == HALTED) & ~rst;
  assign timeout_err  = timeout_q;
  assign state        = state_q;

`ifdef PIPE_PERF_EN
  logic        dmem_ev, imem_ev, lu_ev;
  logic [15:0] dmem_q, imem_q, lu_q;

  // memwb_bubble is raised exactly when EX/MEM is frozen for a data-memory wait
  assign dmem_ev = memwb_bub_c & ~rst;
  assign imem_ev = ~pc_en_c & ~rst &
                   ((state_q == IWAIT) || ((state_q == RUN) && exmem_en_c && imem_stall));
  assign lu_ev   = idex_bub_c & ~ifid_en_c & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_q <= '0;
      imem_q <= '0;
      lu_q   <= '0;
    end else begin
      if (dmem_ev && !(&dmem_q)) dmem_q <= dmem_q + 16'd1;
      if (imem_ev && !(&imem_q)) imem_q <= imem_q + 16'd1;
      if (lu_ev && !(&lu_q))     lu_q   <= lu_q + 16'd1;
    end
  end

  assign stall_dmem_cnt = dmem_q;
  assign stall_imem_cnt = imem_q;
  assign lu_bubble_cnt  = lu_q;
`else
  assign stall_dmem_cnt = 16'd0;
  assign stall_imem_cnt = 16'd0;
  assign lu_bubble_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed scenarios plus random traffic against a stage-freeze reference model.
module tb_pipe_stall_ctrl;

  localparam int TW   = 3;
  localparam int WMAX = (1 << TW) - 1;
`ifdef PIPE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk, rst;
  logic imem_stall, imem_done, dmem_stall, dmem_done, load_use, branch_flush, halt_mem;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_bubble, idex_bubble, memwb_bubble, imem_cancel, halted, timeout_err;
  logic [1:0]  state;
  logic [15:0] stall_dmem_cnt, stall_imem_cnt, lu_bubble_cnt;

  pipe_stall_ctrl #(.TIMEOUT_W(TW)) dut (
    .clk(clk), .rst(rst),
    .imem_stall(imem_stall), .imem_done(imem_done),
    .dmem_stall(dmem_stall), .dmem_done(dmem_done),
    .load_use(load_use), .branch_flush(branch_flush), .halt_mem(halt_mem),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_bubble(ifid_bubble), .idex_bubble(idex_bubble), .memwb_bubble(memwb_bubble),
    .imem_cancel(imem_cancel), .halted(halted), .timeout_err(timeout_err), .state(state),
    .stall_dmem_cnt(stall_dmem_cnt), .stall_imem_cnt(stall_imem_cnt), .lu_bubble_cnt(lu_bubble_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_err = 0;
  int n_cyc = 0;

  // Reference model: each cycle picks one action, which freezes the top N stages
  // and drops a bubble into specific registers.
  typedef enum {ACT_GO, ACT_DMEM, ACT_HALT, ACT_FLUSH, ACT_FETCH, ACT_LU, ACT_STOP} act_t;
  act_t       act;
  bit         fetch_lu;
  int         m_state, m_wait, m_sd, m_si, m_lu;
  bit         m_pend, m_to;
  logic [4:0] x_en;   // {pc, ifid, idex, exmem, memwb}
  logic [2:0] x_bub;  // {ifid, idex, memwb}
  logic       x_cancel;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=0x%0h expected=0x%0h", tag, n_cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_pend = 1'b0; m_wait = 0; m_to = 1'b0;
    m_sd = 0; m_si = 0; m_lu = 0;
  endtask

  task automatic model_eval();
    int frz;
    x_cancel = 1'b0;
    fetch_lu = 1'b0;
    frz      = 0;
    case (m_state)
      0: begin
        if (dmem_stall) act = ACT_DMEM;
        else if (halt_mem) act = ACT_HALT;
        else if (branch_flush) begin act = ACT_FLUSH; x_cancel = imem_stall; end
        else if (imem_stall) begin act = ACT_FETCH; fetch_lu = load_use; end
        else if (load_use) act = ACT_LU;
        else act = ACT_GO;
      end
      1: begin
        if (dmem_stall) act = ACT_DMEM;
        else if (halt_mem) act = ACT_HALT;
        else if (branch_flush) begin act = ACT_FLUSH; x_cancel = 1'b1; end
        else if (imem_done) act = load_use ? ACT_LU : ACT_GO;
        else begin act = ACT_FETCH; fetch_lu = load_use; end
      end
      2: act = dmem_done ? ACT_GO : ACT_DMEM;
      default: act = ACT_STOP;
    endcase
    case (act)
      ACT_GO:    begin frz = 0; x_bub = 3'b000; end
      ACT_FLUSH: begin frz = 0; x_bub = 3'b110; end
      ACT_FETCH: begin frz = fetch_lu ? 2 : 1; x_bub = fetch_lu ? 3'b010 : 3'b100; end
      ACT_LU:    begin frz = 2; x_bub = 3'b010; end
      ACT_DMEM:  begin frz = 4; x_bub = 3'b001; end
      ACT_HALT:  begin frz = 4; x_bub = 3'b000; end
      default:   begin frz = 5; x_bub = 3'b000; end
    endcase
    x_en = 5'b11111 >> frz;
  endtask

  task automatic model_step();
    int  nstate;
    bit  was_wait;
    was_wait = (m_state == 1) || (m_state == 2);
    if (act == ACT_DMEM && m_sd < 65535) m_sd++;
    if (((m_state == 1 && !x_en[4]) || (m_state == 0 && act == ACT_FETCH)) && m_si < 65535) m_si++;
    if ((act == ACT_LU || (act == ACT_FETCH && fetch_lu)) && m_lu < 65535) m_lu++;
    case (act)
      ACT_DMEM: begin
        nstate = 2;
        if (m_state == 0) m_pend = imem_stall;
        else if (m_state == 1) m_pend = !imem_done;
        else if (imem_done) m_pend = 1'b0;
      end
      ACT_HALT, ACT_STOP: nstate = 3;
      ACT_FETCH: nstate = 1;
      ACT_GO: begin
        if (m_state == 2) begin
          if (imem_done) m_pend = 1'b0;
          nstate = m_pend ? 1 : 0;
        end else begin
          nstate = 0;
        end
      end
      default: nstate = 0;
    endcase
    if (was_wait) begin
      if (m_wait < WMAX) m_wait++;
      if (m_wait == WMAX) m_to = 1'b1;
    end
    if (nstate == 0) m_wait = 0;
    m_state = nstate;
  endtask

  task automatic check_outputs();
    check("en", 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en}), 32'(x_en));
    check("bubble", 32'({ifid_bubble, idex_bubble, memwb_bubble}), 32'(x_bub));
    check("imem_cancel", 32'(imem_cancel), 32'(x_cancel));
    check("halted", 32'(halted), 32'(m_state == 3));
    check("state", 32'(state), 32'(m_state));
    check("timeout_err", 32'(timeout_err), 32'(m_to));
    check("stall_dmem_cnt", 32'(stall_dmem_cnt), PERF ? 32'(m_sd) : 32'd0);
    check("stall_imem_cnt", 32'(stall_imem_cnt), PERF ? 32'(m_si) : 32'd0);
    check("lu_bubble_cnt", 32'(lu_bubble_cnt), PERF ? 32'(m_lu) : 32'd0);
  endtask

  // Starts and ends on a falling edge.
  task automatic cyc(input logic i_s, input logic i_d, input logic d_s, input logic d_d,
                     input logic l_u, input logic b_f, input logic h_m);
    imem_stall = i_s; imem_done = i_d; dmem_stall = d_s; dmem_done = d_d;
    load_use = l_u; branch_flush = b_f; halt_mem = h_m;
    #1;
    model_eval();
    check_outputs();
    @(posedge clk);
    model_step();
    n_cyc++;
    @(negedge clk);
  endtask

  task automatic check_in_reset(input string tag);
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_en"}, 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en}), 32'd0);
    check({tag, "_bub"}, 32'({ifid_bubble, idex_bubble, memwb_bubble, imem_cancel}), 32'd0);
    check({tag, "_halt_to"}, 32'({halted, timeout_err}), 32'd0);
    check({tag, "_cnt"}, 32'(stall_dmem_cnt | stall_imem_cnt | lu_bubble_cnt), 32'd0);
  endtask

  // Reset asserted between clock edges, so the checks see the asynchronous effect.
  task automatic do_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    check_in_reset(tag);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b1;
    imem_stall = 0; imem_done = 0; dmem_stall = 0; dmem_done = 0;
    load_use = 0; branch_flush = 0; halt_mem = 0;
    model_reset();
    #1;
    check_in_reset("por");
    @(negedge clk);
    rst = 1'b0;

    // data-memory stall for three cycles, then completion
    repeat (3) cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    check("dstall_state", 32'(state), 32'd0);
    check("dstall_cnt", 32'(stall_dmem_cnt), PERF ? 32'd3 : 32'd0);
    check("dstall_no_to", 32'(timeout_err), 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // single load-use cycle
    do_reset("rst_a");
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("lu_state", 32'(state), 32'd0);
    check("lu_cnt", 32'(lu_bubble_cnt), PERF ? 32'd1 : 32'd0);

    // fetch wait, data stall arrives, fetch completes under it, then data completes
    do_reset("rst_b");
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    check("iw_state", 32'(state), 32'd1);
    cyc(1, 0, 1, 0, 0, 0, 0);
    check("dw_state", 32'(state), 32'd2);
    cyc(0, 1, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    check("idw_state", 32'(state), 32'd0);
    check("idw_imem_cnt", 32'(stall_imem_cnt), PERF ? 32'd3 : 32'd0);
    check("idw_dmem_cnt", 32'(stall_dmem_cnt), PERF ? 32'd2 : 32'd0);

    // taken branch while a fetch is outstanding in RUN
    cyc(1, 0, 0, 0, 0, 1, 0);
    check("flush_state", 32'(state), 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // halt is terminal regardless of later inputs
    cyc(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++)
      cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    check("halt_state", 32'(state), 32'd3);
    check("halt_flag", 32'(halted), 32'd1);

    // reset in the middle of a data wait with the stall still high
    do_reset("rst_c");
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    do_reset("rst_mid_dwait");
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("rst_release_en", 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en}), 32'h1f);

    // watchdog: seven stall cycles then completion gives 2^TW-1 wait cycles
    do_reset("rst_d");
    repeat (7) cyc(0, 0, 1, 0, 0, 0, 0);
    check("wd_before", 32'(timeout_err), 32'd0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    check("wd_set", 32'(timeout_err), 32'd1);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0);
    check("wd_sticky", 32'(timeout_err), 32'd1);

    // randomized traffic
    for (int seg = 0; seg < 5; seg++) begin
      do_reset("rst_rand");
      for (int i = 0; i < 200; i++)
        cyc($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 30,
            $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 30,
            $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10,
            $urandom_range(0, 99) < 2);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
